// File: rtl/r5p_gpr_rdu.sv
// GPR read unit: 31-entry register file with write-back bypass, a busy scoreboard
// for pending writes, and a registered valid/ready operand stage toward execute.
module r5p_gpr_rdu #(
    parameter int XLEN    = 32,
    parameter int NUM_PND = 1
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic [4:0]      req_rs1,
    input  logic [4:0]      req_rs2,
    input  logic            req_re1,
    input  logic            req_re2,
    input  logic [4:0]      req_rd,
    input  logic            req_we,
    input  logic            wb_wen,
    input  logic [4:0]      wb_adr,
    input  logic [XLEN-1:0] wb_dat,
    output logic            opr_vld,
    input  logic            opr_rdy,
    output logic [XLEN-1:0] opr_rs1,
    output logic [XLEN-1:0] opr_rs2,
    output logic [4:0]      opr_rd
);

    logic [XLEN-1:0] gpr [1:31];
    logic [31:0]     busy;

    logic            clr1, clr2, clrd;
    logic            h1, h2, hw;
    logic            acc;
    logic [XLEN-1:0] rs1_val, rs2_val;

    // A write-back landing this cycle both clears the hazard and supplies the data.
    always_comb begin
        clr1    = wb_wen && (wb_adr == req_rs1);
        clr2    = wb_wen && (wb_adr == req_rs2);
        clrd    = wb_wen && (wb_adr == req_rd);
        h1      = req_re1 && busy[req_rs1] && !clr1;
        h2      = req_re2 && busy[req_rs2] && !clr2;
        hw      = req_we && (int'(busy[req_rd]) >= NUM_PND) && !clrd;
        req_rdy = (!opr_vld || opr_rdy) && !h1 && !h2 && !hw;
        acc     = req_vld && req_rdy;

        rs1_val = '0;
        if (req_re1 && (req_rs1 != 5'd0))
            rs1_val = clr1 ? wb_dat : gpr[req_rs1];
        rs2_val = '0;
        if (req_re2 && (req_rs2 != 5'd0))
            rs2_val = clr2 ? wb_dat : gpr[req_rs2];
    end

    // Entries are not reset; a write-back arriving during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst && wb_wen && (wb_adr != 5'd0))
            gpr[wb_adr] <= wb_dat;
    end

    // The set is written last so an issue claiming rd wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            if (wb_wen)
                busy[wb_adr] <= 1'b0;
            if (acc && req_we && (req_rd != 5'd0))
                busy[req_rd] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            opr_vld <= 1'b0;
            opr_rs1 <= '0;
            opr_rs2 <= '0;
            opr_rd  <= '0;
        end else if (acc) begin
            opr_vld <= 1'b1;
            opr_rs1 <= rs1_val;
            opr_rs2 <= rs2_val;
            opr_rd  <= req_rd;
        end else if (opr_rdy) begin
            opr_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_r5p_gpr_rdu.sv
// Scoreboard bench for r5p_gpr_rdu: issued requests push expected operands,
// a negedge monitor pops and compares on every operand handshake.
module tb_r5p_gpr_rdu;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic        req_re1;
    logic        req_re2;
    logic [4:0]  req_rd;
    logic        req_we;
    logic        wb_wen;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat;
    logic        opr_vld;
    logic        opr_rdy;
    logic [31:0] opr_rs1;
    logic [31:0] opr_rs2;
    logic [4:0]  opr_rd;

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];

    r5p_gpr_rdu #(.XLEN(32), .NUM_PND(1)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_re1(req_re1), .req_re2(req_re2),
        .req_rd(req_rd), .req_we(req_we),
        .wb_wen(wb_wen), .wb_adr(wb_adr), .wb_dat(wb_dat),
        .opr_vld(opr_vld), .opr_rdy(opr_rdy),
        .opr_rs1(opr_rs1), .opr_rs2(opr_rs2), .opr_rd(opr_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one request and wait up to max_wait cycles for it to be accepted.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic re1, input logic re2,
                                 input logic [4:0] rd, input logic we,
                                 input logic [31:0] e1, input logic [31:0] e2,
                                 input int max_wait);
        exp_t e;
        logic accepted;
        accepted = 1'b0;
        req_rs1 = rs1; req_rs2 = rs2; req_re1 = re1; req_re2 = re2;
        req_rd  = rd;  req_we  = we;  req_vld = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                e.rs1 = e1; e.rs2 = e2; e.rd = rd;
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            step();
            if (accepted) break;
        end
        req_vld = 1'b0;
        checkOutput("accept", {31'd0, accepted}, 32'd1);
    endtask

    task automatic holdStall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("stall_req_rdy", {31'd0, req_rdy}, 32'd0);
            step();
        end
    endtask

    task automatic setReq(input logic [4:0] rs1, input logic re1, input logic [4:0] rd, input logic we);
        req_rs1 = rs1; req_re1 = re1; req_rs2 = 5'd0; req_re2 = 1'b0;
        req_rd  = rd;  req_we  = we;  req_vld = 1'b1;
    endtask

    task automatic setWb(input logic en, input logic [4:0] adr, input logic [31:0] dat);
        wb_wen = en; wb_adr = adr; wb_dat = dat;
    endtask

    always @(negedge clk) begin
        if (rst && opr_vld && opr_rdy) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_opr_vld", {31'd0, opr_vld}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("opr_rs1", opr_rs1, e.rs1);
                checkOutput("opr_rs2", opr_rs2, e.rs2);
                checkOutput("opr_rd", {27'd0, opr_rd}, {27'd0, e.rd});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; req_vld = 1'b0; req_rs1 = '0; req_rs2 = '0; req_re1 = 1'b0; req_re2 = 1'b0;
        req_rd = '0; req_we = 1'b0; opr_rdy = 1'b1;
        setWb(1'b0, 5'd0, 32'd0);
        step(); step();
        checkOutput("reset_opr_vld", {31'd0, opr_vld}, 32'd0);
        checkOutput("reset_opr_rs1", opr_rs1, 32'd0);
        checkOutput("reset_opr_rd", {27'd0, opr_rd}, 32'd0);
        rst = 1'b1;
        step();

        // Basic read after a write-back
        setWb(1'b1, 5'd5, 32'h1234_5678);
        step();
        setWb(1'b0, 5'd0, 32'd0);
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 32'h1234_5678, 32'd0, 1);
        checkOutput("latency_opr_vld", {31'd0, opr_vld}, 32'd1);

        // Same-cycle bypass, then storage read of the same register
        setWb(1'b1, 5'd7, 32'hDEAD_BEEF);
        applyStimulus(5'd7, 5'd5, 1'b1, 1'b1, 5'd2, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1);
        setWb(1'b0, 5'd0, 32'd0);
        applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd2, 1'b0, 32'hDEAD_BEEF, 32'd0, 1);

        // RAW: rd=3 pending blocks a reader until its write-back arrives
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 32'd0, 32'd0, 1);
        setReq(5'd3, 1'b1, 5'd4, 1'b0);
        holdStall(3);
        setWb(1'b1, 5'd3, 32'h42);
        applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b0, 32'h42, 32'd0, 1);
        setWb(1'b0, 5'd0, 32'd0);

        // WAW on x9; a re-issue in the clearing cycle keeps x9 busy
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 32'd0, 32'd0, 1);
        setReq(5'd0, 1'b0, 5'd9, 1'b1);
        holdStall(2);
        setWb(1'b1, 5'd9, 32'h99);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 32'd0, 32'd0, 1);
        setWb(1'b0, 5'd0, 32'd0);
        setReq(5'd9, 1'b1, 5'd10, 1'b0);
        holdStall(1);
        setWb(1'b1, 5'd9, 32'hAA);
        applyStimulus(5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b0, 32'hAA, 32'd0, 1);
        setWb(1'b0, 5'd0, 32'd0);

        // x0 is never busy and always reads zero
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 32'd0, 1);
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 32'd0, 32'd0, 1);
        setWb(1'b1, 5'd0, 32'hFFFF_FFFF);
        applyStimulus(5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b0, 32'd0, 32'd0, 1);
        setWb(1'b0, 5'd0, 32'd0);
        applyStimulus(5'd0, 5'd9, 1'b1, 1'b1, 5'd11, 1'b0, 32'd0, 32'hAA, 1);
        step();

        // Back-pressure holds the output stage and blocks issue
        opr_rdy = 1'b0;
        applyStimulus(5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 32'h1234_5678, 32'd0, 1);
        setReq(5'd7, 1'b1, 5'd12, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
            checkOutput("bp_opr_vld", {31'd0, opr_vld}, 32'd1);
            checkOutput("bp_opr_rs1", opr_rs1, 32'h1234_5678);
            checkOutput("bp_opr_rd", {27'd0, opr_rd}, 32'd6);
            step();
        end
        opr_rdy = 1'b1;
        applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0, 32'hDEAD_BEEF, 32'd0, 1);
        step();

        // Reset mid-operation with x3 busy and a write-back in the reset cycle
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 32'd0, 32'd0, 1);
        step();
        rst = 1'b0;
        setWb(1'b1, 5'd5, 32'hBAD0_BAD0);
        step();
        rst = 1'b1;
        setWb(1'b0, 5'd0, 32'd0);
        checkOutput("rst_opr_vld", {31'd0, opr_vld}, 32'd0);
        checkOutput("rst_opr_rd", {27'd0, opr_rd}, 32'd0);
        checkOutput("rst_opr_rs1", opr_rs1, 32'd0);
        req_rs1 = 5'd3; req_re1 = 1'b1; req_rd = 5'd3; req_we = 1'b1; req_vld = 1'b0;
        #1;
        checkOutput("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        applyStimulus(5'd5, 5'd3, 1'b1, 1'b1, 5'd13, 1'b0, 32'h1234_5678, 32'h42, 1);

        step(); step();
        checkOutput("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/r5p_gpr_rdu.md
# r5p_gpr_rdu

GPR read unit with write-back bypass and register scoreboard. It sits between instruction decode and execute and is the read-side partner of the write-back unit. It stores the 31 writable general purpose registers and accepts the write-back port (wen/adr/dat). It delivers registered rs1/rs2 operands through a valid/ready handshake, stalling issue while a source or destination register still has a write pending.

## Interface
- XLEN, 32, register/data width
- NUM_PND, 1, max outstanding writes per register; fixed at 1 (second write to a busy rd stalls)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- req_vld  in  1  issue request valid
- req_rdy  out  1  issue request accepted when req_vld & req_rdy
- req_rs1  in  5  source 1 address
- req_rs2  in  5  source 2 address
- req_re1  in  1  source 1 read enable
- req_re2  in  1  source 2 read enable
- req_rd  in  5  destination address of the issuing instruction
- req_we  in  1  issuing instruction will later write rd
- wb_wen  in  1  write-back enable (from write-back unit)
- wb_adr  in  5  write-back address
- wb_dat  in  XLEN  write-back data
- opr_vld  out  1  operands valid
- opr_rdy  in  1  execute stage accepts operands
- opr_rs1  out  XLEN  source 1 operand
- opr_rs2  out  XLEN  source 2 operand
- opr_rd  out  5  destination address, forwarded

## Operation
- Storage: 31 x XLEN entries for x1..x31, not reset. x0 always reads 0 and is never written; writes to x0 are ignored.
- Write: when wb_wen=1 and wb_adr!=0, entry wb_adr <= wb_dat, and busy[wb_adr] <= 0 at the clock edge.
- Scoreboard: 32-bit busy vector; busy[0] is constant 0.
- Hazard terms (combinational). "clr(a)" = wb_wen & wb_adr==a.
  - h1 = req_re1 & busy[req_rs1] & !clr(req_rs1)
  - h2 = req_re2 & busy[req_rs2] & !clr(req_rs2)
  - hw = req_we & busy[req_rd] & !clr(req_rd)
- Ready: req_rdy = (!opr_vld | opr_rdy) & !h1 & !h2 & !hw. req_rdy is independent of req_vld.
- On accept, each operand is loaded with:
  - 0 if its read enable is 0 or its address is 0;
  - otherwise wb_dat if clr(addr), i.e. write-first bypass;
  - otherwise the stored entry.
- On accept: opr_rd <= req_rd, opr_vld <= 1.
- On accept with req_we=1 and req_rd!=0, busy[req_rd] <= 1. This set wins over a simultaneous clear of the same index.
- Output register:
  - No accept and opr_rdy=1: opr_vld <= 0; data holds its last value.
  - opr_vld=1 and opr_rdy=0: opr_* stays stable.
- Reset (rst=0 at a clock edge):
  - busy <= 0, opr_vld <= 0, opr_rs1/opr_rs2 <= 0, opr_rd <= 0.
  - Register entries are unchanged.
  - A write-back present in the reset cycle is dropped.
- No state machine beyond the 1-deep output stage and the busy vector. Ordering is guaranteed because every busy register stalls all readers and writers.

## Timing
- Accept to opr_vld: 1 cycle. Throughput: 1 operand set per cycle when hazard-free and opr_rdy=1.
- Write-back to read visibility:
  - same cycle via bypass;
  - from storage in the following cycle.
- Stall release: req_rdy rises combinationally in the cycle wb_wen clears the hazard, so no extra bubble.
- Combinational paths:
  - wb_wen/wb_adr -> req_rdy
  - opr_rdy -> req_rdy
  - opr_vld never depends combinationally on an input.
- Cycle after reset release: req_rdy=1 for any request (busy empty, opr_vld=0).

## Test plan
- Basic read: write x5=0x1234_5678, next cycle issue rs1=5, rs2=0, re1=re2=1, opr_rdy=1. Expect opr_vld=1 one cycle later, opr_rs1=0x1234_5678, opr_rs2=0.
- Bypass: issue rs1=7 in the same cycle as wb_wen=1, wb_adr=7, wb_dat=0xDEAD_BEEF. Expect opr_rs1=0xDEAD_BEEF, no stall.
- Scoreboard RAW:
  - Issue rd=3 with we=1, then rs1=3. Expect req_rdy=0 until wb_wen with adr=3, dat=0x42.
  - req_rdy=1 in that same cycle; opr_rs1=0x42.
- WAW plus x0:
  - Issue rd=9 we=1, then again rd=9 we=1. Expect a stall until rd=9 is written back.
  - Issue rd=0 we=1 twice. Expect no stall; a write-back to x0 leaves reads at 0.
- Back-pressure: hold opr_rdy=0 with opr_vld=1. Expect req_rdy=0 and opr_* stable for 5 cycles; on opr_rdy=1, the next accept proceeds in that cycle.
- Reset mid-operation:
  - Make x3 busy, assert rst=0 for one cycle.
  - Expect opr_vld=0, and req_rdy=1 for rs1=3 after release.
  - Register contents written before reset still read back.
